// File: rtl/decode_queue.sv
// RV32I decode stage: decodes fetched (pc, inst) at enqueue and buffers up to DEPTH uops in a circular FIFO.
// uop_info_o layout (MSB..LSB): pc, inst, dnpc, imm, rs1, rs2, rd, rd_wen, fu[1:0], fu_op[3:0], fu_func[3:0], load_type[2:0], store_type[1:0], ecall, ebreak.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [31:0]        inst_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [3*XLEN+64:0] uop_info_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int UOP_W = 3 * XLEN + 65;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] FU_NONE = 2'd0;
    localparam logic [1:0] FU_ALU  = 2'd1;
    localparam logic [1:0] FU_LSU  = 2'd2;

    localparam logic [3:0] OP_NONE   = 4'd0;
    localparam logic [3:0] OP_LUI    = 4'd1;
    localparam logic [3:0] OP_AUIPC  = 4'd2;
    localparam logic [3:0] OP_JAL    = 4'd3;
    localparam logic [3:0] OP_JALR   = 4'd4;
    localparam logic [3:0] OP_BRANCH = 4'd5;
    localparam logic [3:0] OP_LOAD   = 4'd6;
    localparam logic [3:0] OP_STORE  = 4'd7;
    localparam logic [3:0] OP_ALI    = 4'd8;
    localparam logic [3:0] OP_ALR    = 4'd9;
    localparam logic [3:0] OP_SYSTEM = 4'd10;

    logic [UOP_W-1:0] uop_q [DEPTH];
    logic [DEPTH-1:0] ill_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
        logic signed [XLEN-1:0] r;
        r = v;
        return r;
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Returns {illegal, uop}; fu_func is {fun7[5] for SUB/SRA/SRAI, fun3} on the ALU and fun3 on branches.
    function automatic logic [UOP_W:0] decode(input logic [XLEN-1:0] pc, input logic [31:0] inst);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [31:0] imm32;
        logic [3:0] op;
        logic [3:0] func;
        logic [1:0] fu;
        logic [2:0] ld;
        logic [1:0] st;
        logic       ill;
        logic       is_ecall;
        logic       is_ebreak;
        logic       wen;
        opc       = inst[6:0];
        f3        = inst[14:12];
        f7        = inst[31:25];
        rd        = inst[11:7];
        imm32     = '0;
        op        = OP_NONE;
        func      = '0;
        fu        = FU_NONE;
        ld        = '0;
        st        = '0;
        ill       = 1'b0;
        is_ecall  = (inst == 32'h0000_0073);
        is_ebreak = (inst == 32'h0010_0073);
        case (opc)
            7'b0110111: begin op = OP_LUI;   imm32 = imm_u(inst); end
            7'b0010111: begin op = OP_AUIPC; imm32 = imm_u(inst); end
            7'b1101111: begin op = OP_JAL;   imm32 = imm_j(inst); end
            7'b1100111: begin
                op = OP_JALR; imm32 = imm_i(inst);
                ill = (f3 != 3'b000);
            end
            7'b1100011: begin
                op = OP_BRANCH; imm32 = imm_b(inst); func = {1'b0, f3};
                ill = (f3[2:1] == 2'b01);
            end
            7'b0000011: begin
                op = OP_LOAD; fu = FU_LSU; imm32 = imm_i(inst); ld = f3;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            7'b0100011: begin
                op = OP_STORE; fu = FU_LSU; imm32 = imm_s(inst); st = f3[1:0];
                ill = (f3 >= 3'b011);
            end
            7'b0010011: begin
                op = OP_ALI; fu = FU_ALU; imm32 = imm_i(inst);
                func = {(f3 == 3'b101) && f7[5], f3};
                if (f3 == 3'b001)
                    ill = (f7 != 7'd0);
                else if (f3 == 3'b101)
                    ill = (f7 != 7'd0) && (f7 != 7'b0100000);
            end
            7'b0110011: begin
                op = OP_ALR; fu = FU_ALU; imm32 = imm_i(inst); func = {f7[5], f3};
                ill = !((f7 == 7'd0) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            7'b1110011: begin
                op = OP_SYSTEM;
                ill = !(is_ecall || is_ebreak);
            end
            default: ill = 1'b1;
        endcase
        if (inst[1:0] != 2'b11)
            ill = 1'b1;
        if (ill) begin
            op        = OP_NONE;
            fu        = FU_NONE;
            is_ecall  = 1'b0;
            is_ebreak = 1'b0;
        end
        wen = !ill && (op != OP_BRANCH) && (op != OP_STORE) && (rd != 5'd0);
        return {ill, pc, inst, {XLEN{1'b0}}, sext(imm32), inst[19:15], inst[24:20], rd,
                wen, fu, op, func, ld, st, is_ecall, is_ebreak};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o  = (count_q < CNT_W'(DEPTH)) && !flush_i;
    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;
    assign uop_info_o  = uop_q[rd_ptr_q];
    assign illegal_o   = out_valid_o && ill_q[rd_ptr_q];

    always_comb begin
        push     = in_valid_i && in_ready_o;
        pop      = out_valid_o && out_ready_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)
                rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload is qualified by count, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push)
            {ill_q[wr_ptr_q], uop_q[wr_ptr_q]} <= decode(pc_i, inst_i);
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vector table, FIFO corner sequences and a randomized queue-model run.
module tb_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] FU_NONE = 2'd0, FU_ALU = 2'd1, FU_LSU = 2'd2;
    localparam logic [3:0] OP_NONE = 4'd0, OP_LUI = 4'd1, OP_AUIPC = 4'd2, OP_JAL = 4'd3,
                           OP_JALR = 4'd4, OP_BRANCH = 4'd5, OP_LOAD = 4'd6, OP_STORE = 4'd7,
                           OP_ALI = 4'd8, OP_ALR = 4'd9, OP_SYSTEM = 4'd10;
    localparam int F_N = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] dnpc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [1:0]  fu;
        logic [3:0]  fu_op;
        logic [3:0]  fu_func;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic        ecall;
        logic        ebreak;
    } uop_t;

    typedef struct packed {
        uop_t u;
        logic ill;
    } exp_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  op;
        logic [1:0]  fu;
        logic [3:0]  func;
        logic [2:0]  ld;
        logic [1:0]  st;
        int          fmt;
    } pat_t;

    typedef struct {
        logic [31:0] inst;
        logic        ill;
        logic [1:0]  fu;
        logic [3:0]  op;
        logic [3:0]  func;
        logic [31:0] imm;
        logic        wen;
        logic        ecall;
        logic        ebreak;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0]      pc, inst;
    logic [160:0]     uop_info;
    logic [CNT_W-1:0] count;
    uop_t             head;
    assign head = uop_info;

    int   errors = 0;
    int   checks = 0;
    pat_t pats[$];
    exp_t mq[$];

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .pc_i       (pc),
        .inst_i     (inst),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .uop_info_o (uop_info),
        .illegal_o  (illegal),
        .count_o    (count)
    );

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_pat(input logic [31:0] mask, input logic [31:0] match, input logic [3:0] op,
                           input logic [1:0] fu, input logic [3:0] func, input logic [2:0] ld,
                           input logic [1:0] st, input int fmt);
        pat_t p;
        p.mask = mask; p.match = match; p.op = op; p.fu = fu;
        p.func = func; p.ld = ld; p.st = st; p.fmt = fmt;
        pats.push_back(p);
    endtask

    // Every legal RV32I encoding as a mask/match pattern with the expected uop classification.
    task automatic build_patterns();
        add_pat(32'h7F, 32'h37, OP_LUI, FU_NONE, 0, 0, 0, F_U);
        add_pat(32'h7F, 32'h17, OP_AUIPC, FU_NONE, 0, 0, 0, F_U);
        add_pat(32'h7F, 32'h6F, OP_JAL, FU_NONE, 0, 0, 0, F_J);
        add_pat(32'h707F, 32'h67, OP_JALR, FU_NONE, 0, 0, 0, F_I);
        add_pat(32'h707F, 32'h0063, OP_BRANCH, FU_NONE, 0, 0, 0, F_B);
        add_pat(32'h707F, 32'h1063, OP_BRANCH, FU_NONE, 1, 0, 0, F_B);
        add_pat(32'h707F, 32'h4063, OP_BRANCH, FU_NONE, 4, 0, 0, F_B);
        add_pat(32'h707F, 32'h5063, OP_BRANCH, FU_NONE, 5, 0, 0, F_B);
        add_pat(32'h707F, 32'h6063, OP_BRANCH, FU_NONE, 6, 0, 0, F_B);
        add_pat(32'h707F, 32'h7063, OP_BRANCH, FU_NONE, 7, 0, 0, F_B);
        add_pat(32'h707F, 32'h0003, OP_LOAD, FU_LSU, 0, 0, 0, F_I);
        add_pat(32'h707F, 32'h1003, OP_LOAD, FU_LSU, 0, 1, 0, F_I);
        add_pat(32'h707F, 32'h2003, OP_LOAD, FU_LSU, 0, 2, 0, F_I);
        add_pat(32'h707F, 32'h4003, OP_LOAD, FU_LSU, 0, 4, 0, F_I);
        add_pat(32'h707F, 32'h5003, OP_LOAD, FU_LSU, 0, 5, 0, F_I);
        add_pat(32'h707F, 32'h0023, OP_STORE, FU_LSU, 0, 0, 0, F_S);
        add_pat(32'h707F, 32'h1023, OP_STORE, FU_LSU, 0, 0, 1, F_S);
        add_pat(32'h707F, 32'h2023, OP_STORE, FU_LSU, 0, 0, 2, F_S);
        add_pat(32'h707F, 32'h0013, OP_ALI, FU_ALU, 0, 0, 0, F_I);
        add_pat(32'h707F, 32'h2013, OP_ALI, FU_ALU, 2, 0, 0, F_I);
        add_pat(32'h707F, 32'h3013, OP_ALI, FU_ALU, 3, 0, 0, F_I);
        add_pat(32'h707F, 32'h4013, OP_ALI, FU_ALU, 4, 0, 0, F_I);
        add_pat(32'h707F, 32'h6013, OP_ALI, FU_ALU, 6, 0, 0, F_I);
        add_pat(32'h707F, 32'h7013, OP_ALI, FU_ALU, 7, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00001013, OP_ALI, FU_ALU, 1, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00005013, OP_ALI, FU_ALU, 5, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h40005013, OP_ALI, FU_ALU, 13, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00000033, OP_ALR, FU_ALU, 0, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h40000033, OP_ALR, FU_ALU, 8, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00001033, OP_ALR, FU_ALU, 1, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00002033, OP_ALR, FU_ALU, 2, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00003033, OP_ALR, FU_ALU, 3, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00004033, OP_ALR, FU_ALU, 4, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00005033, OP_ALR, FU_ALU, 5, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h40005033, OP_ALR, FU_ALU, 13, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00006033, OP_ALR, FU_ALU, 6, 0, 0, F_I);
        add_pat(32'hFE00707F, 32'h00007033, OP_ALR, FU_ALU, 7, 0, 0, F_I);
        add_pat(32'hFFFFFFFF, 32'h00000073, OP_SYSTEM, FU_NONE, 0, 0, 0, F_N);
        add_pat(32'hFFFFFFFF, 32'h00100073, OP_SYSTEM, FU_NONE, 0, 0, 0, F_N);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] pc_v, input logic [31:0] inst_v);
        exp_t             e;
        logic signed [31:0] s_i, s_b, s_j;
        bit               hit;
        pat_t             p;
        hit = 1'b0;
        s_i = $signed(inst_v) >>> 20;
        s_b = $signed(inst_v) >>> 19;
        s_j = $signed(inst_v) >>> 11;
        foreach (pats[k])
            if (!hit && ((inst_v & pats[k].mask) == pats[k].match)) begin
                hit = 1'b1;
                p   = pats[k];
            end
        e        = '0;
        e.ill    = !hit;
        e.u.pc   = pc_v;
        e.u.inst = inst_v;
        e.u.rs1  = inst_v[19:15];
        e.u.rs2  = inst_v[24:20];
        e.u.rd   = inst_v[11:7];
        if (hit) begin
            case (p.fmt)
                F_I:     e.u.imm = s_i;
                F_S:     e.u.imm = {s_i[31:5], inst_v[11:7]};
                F_B:     e.u.imm = (s_b & 32'hFFFFF000) | (32'(inst_v[7]) << 11) |
                                   (32'(inst_v[30:25]) << 5) | (32'(inst_v[11:8]) << 1);
                F_U:     e.u.imm = inst_v & 32'hFFFFF000;
                F_J:     e.u.imm = (s_j & 32'hFFF00000) | (32'(inst_v[19:12]) << 12) |
                                   (32'(inst_v[20]) << 11) | (32'(inst_v[30:21]) << 1);
                default: e.u.imm = '0;
            endcase
            e.u.fu_op   = p.op;
            e.u.fu      = p.fu;
            e.u.fu_func = p.func;
            e.u.ld      = p.ld;
            e.u.st      = p.st;
            e.u.ecall   = (inst_v == 32'h0000_0073);
            e.u.ebreak  = (inst_v == 32'h0010_0073);
            e.u.rd_wen  = (p.op != OP_BRANCH) && (p.op != OP_STORE) && (inst_v[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        int          r;
        pat_t        p;
        logic [31:0] rnd;
        r   = $urandom_range(0, 9);
        p   = pats[$urandom_range(0, pats.size() - 1)];
        rnd = $urandom;
        if (r < 6)
            return (rnd & ~p.mask) | p.match;
        else if (r < 8)
            return (rnd & ~32'h7F) | (p.match & 32'h7F);
        return rnd;
    endfunction

    task automatic chk_head(input string nm, input exp_t e);
        chk({nm, " illegal"}, illegal, e.ill);
        if (e.ill)
            chk({nm, " ill_fields"},
                {head.pc, head.inst, head.fu_op, head.fu, head.rd_wen, head.ecall, head.ebreak},
                {e.u.pc, e.u.inst, e.u.fu_op, e.u.fu, e.u.rd_wen, e.u.ecall, e.u.ebreak});
        else
            chk({nm, " uop"}, head, e.u);
    endtask

    task automatic enq(input logic [31:0] pc_v, input logic [31:0] inst_v);
        in_valid = 1'b1; pc = pc_v; inst = inst_v;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] pq[$];
        exp_t        e;
        bit          acc, pp;

        build_patterns();
        vecs.push_back('{32'h00500093, 0, FU_ALU,  OP_ALI,    4'd0,  32'h00000005, 1, 0, 0});
        vecs.push_back('{32'hFFFFFFFF, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'h00000073, 0, FU_NONE, OP_SYSTEM, 4'd0,  32'h0,        0, 1, 0});
        vecs.push_back('{32'h00100073, 0, FU_NONE, OP_SYSTEM, 4'd0,  32'h0,        0, 0, 1});
        vecs.push_back('{32'hFE20AE23, 0, FU_LSU,  OP_STORE,  4'd0,  32'hFFFFFFFC, 0, 0, 0});
        vecs.push_back('{32'h00208463, 0, FU_NONE, OP_BRANCH, 4'd0,  32'h00000008, 0, 0, 0});
        vecs.push_back('{32'h402081B3, 0, FU_ALU,  OP_ALR,    4'd8,  32'h00000402, 1, 0, 0});
        vecs.push_back('{32'h40335293, 0, FU_ALU,  OP_ALI,    4'd13, 32'h00000403, 1, 0, 0});
        vecs.push_back('{32'h40009093, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'h12345037, 0, FU_NONE, OP_LUI,    4'd0,  32'h12345000, 0, 0, 0});
        vecs.push_back('{32'hFFDFF0EF, 0, FU_NONE, OP_JAL,    4'd0,  32'hFFFFFFFC, 1, 0, 0});
        vecs.push_back('{32'h0000B083, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'h0000A063, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'h00001067, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'h4000C033, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'h00000001, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});
        vecs.push_back('{32'hFFF14383, 0, FU_LSU,  OP_LOAD,   4'd0,  32'hFFFFFFFF, 1, 0, 0});
        vecs.push_back('{32'h80000517, 0, FU_NONE, OP_AUIPC,  4'd0,  32'h80000000, 1, 0, 0});
        vecs.push_back('{32'h34011073, 1, FU_NONE, OP_NONE,   4'd0,  32'h0,        0, 0, 0});

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pc = '0; inst = '0;
        @(negedge clk);
        tick();
        tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset illegal", illegal, 0);
        chk("reset count", count, 0);
        chk("reset in_ready", in_ready, 1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            in_valid = 1'b1; out_ready = 1'b1;
            pc = 32'h8000_0000 + 32'(i) * 4; inst = vecs[i].inst;
            #1 chk("vec in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d count", i), count, 1);
            chk($sformatf("vec%0d illegal", i), illegal, vecs[i].ill);
            chk($sformatf("vec%0d pc/inst", i), {head.pc, head.inst}, {pc, vecs[i].inst});
            chk($sformatf("vec%0d fu/op/wen", i), {head.fu, head.fu_op, head.rd_wen},
                {vecs[i].fu, vecs[i].op, vecs[i].wen});
            chk($sformatf("vec%0d ecall/ebreak", i), {head.ecall, head.ebreak},
                {vecs[i].ecall, vecs[i].ebreak});
            if (!vecs[i].ill)
                chk($sformatf("vec%0d func/imm", i), {head.fu_func, head.imm},
                    {vecs[i].func, vecs[i].imm});
            if (vecs[i].inst == 32'hFE20AE23)
                chk("sw store_type", head.st, 2);
            chk_head($sformatf("vec%0d model", i), ref_decode(pc, vecs[i].inst));
            tick();
            chk($sformatf("vec%0d drained", i), count, 0);
        end
        out_ready = 1'b0;

        for (int i = 0; i <= DEPTH; i++) begin
            in_valid = 1'b1; pc = 32'h100 + 32'(i) * 4; inst = 32'h00000013;
            #1 chk($sformatf("fill%0d in_ready", i), in_ready, (i < DEPTH));
            if (i < DEPTH) pq.push_back(pc);
            tick();
        end
        chk("full count", count, DEPTH);
        chk("full out_valid", out_valid, 1);
        out_ready = 1'b1; pc = 32'h200;
        #1 chk("full+deq in_ready", in_ready, 0);
        tick();
        void'(pq.pop_front());
        chk("full+deq count", count, DEPTH - 1);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            pc = 32'h300 + 32'(k) * 4;
            #1 chk("stream in_ready", in_ready, 1);
            chk($sformatf("stream%0d head pc", k), head.pc, pq[0]);
            tick();
            void'(pq.pop_front());
            pq.push_back(pc);
            chk("stream count", count, DEPTH - 1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < DEPTH + 2 && pq.size() != 0; k++) begin
            chk($sformatf("drain%0d head pc", k), head.pc, pq[0]);
            tick();
            void'(pq.pop_front());
        end
        chk("drain count", count, 0);
        chk("drain out_valid", out_valid, 0);

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) enq(32'h400 + 32'(k) * 4, 32'h00000013);
        chk("pre-flush count", count, 3);
        flush = 1'b1; in_valid = 1'b1; pc = 32'h4F0;
        #1 chk("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush count", count, 0);
        chk("flush out_valid", out_valid, 0);
        tick();
        chk("flush input dropped", count, 0);
        enq(32'h500, 32'h00500093);
        chk("post-flush head pc", head.pc, 32'h500);
        enq(32'h504, 32'h00500093);
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; pc = 32'h508;
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        chk("midreset count", count, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset in_ready", in_ready, 1);

        for (int c = 0; c < 1500; c++) begin
            chk("rnd out_valid", out_valid, mq.size() != 0);
            chk("rnd count", count, mq.size());
            if (mq.size() != 0) chk_head($sformatf("rnd%0d head", c), mq[0]);
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = $urandom_range(0, 1);
            pc        = $urandom & 32'hFFFF_FFFC;
            inst      = gen_inst();
            #1 chk("rnd in_ready", in_ready, (mq.size() < DEPTH) && !flush);
            acc = in_valid && (mq.size() < DEPTH) && !flush;
            pp  = (mq.size() != 0) && out_ready;
            e   = ref_decode(pc, inst);
            tick();
            if (!rst_n || flush) begin
                mq.delete();
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
